// File: rtl/msdap_pkg.sv
// Shared types and sizes for the MSDAP output datapath.
package msdap_pkg;

    localparam int ACC_W = 40;
    localparam int CNT_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/alu_out_serializer_piso_shift.sv
// Parallel-in serial-out shifter: loads a word, presents it MSB first and
// advances one bit per shift enable, flagging the final bit.
module piso_shift #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_load_data,
    input  logic             i_shift_en,
    output logic             o_sout,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(ACC_W - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] r_shift_reg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_last;

    assign w_last = (r_bit_cnt == {CNT_W{1'b0}});
    assign o_done = i_shift_en & w_last;
    assign o_sout = r_shift_reg[ACC_W-1];

    // Load a new word, or step to the next bit; the last step empties the register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_shift_reg <= {ACC_W{1'b0}};
            r_bit_cnt   <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_shift_reg <= i_load_data;
            r_bit_cnt   <= LP_CNT_INIT;
        end else if (i_shift_en) begin
            if (w_last) begin
                r_shift_reg <= {ACC_W{1'b0}};
            end else begin
                r_shift_reg <= {r_shift_reg[ACC_W-2:0], 1'b0};
                r_bit_cnt   <= r_bit_cnt - LP_CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_out_serializer.sv
// Per-channel ALU output serializer: one-deep hold buffer, frame-aligned
// transfer into a PISO shifter, and sticky overrun / frame error flags.
module alu_out_serializer
    import msdap_pkg::*;
#(
    parameter int ACC_W = msdap_pkg::ACC_W,
    parameter int CNT_W = msdap_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [ACC_W-1:0] accum_reg,
    input  logic             output_en,
    input  logic             frame,
    input  logic             bit_en,
    output logic             sout,
    output logic             out_ready,
    output logic             hold_valid,
    output logic             overrun,
    output logic             frame_err
);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_hold_reg;
    logic             r_hold_valid;
    logic             r_out_ready;
    logic             r_overrun;
    logic             r_frame_err;
    logic             w_load;
    logic             w_shift_en;
    logic             w_done;
    logic             w_in_shift;

    assign w_in_shift = (r_state == SHIFT);
    // A transfer only starts from IDLE; frames seen while shifting are errors.
    assign w_load     = (r_state == IDLE) & frame & r_hold_valid;
    assign w_shift_en = w_in_shift & bit_en;

    piso_shift #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk         (clk),
        .clear       (clear),
        .i_load      (w_load),
        .i_load_data (r_hold_reg),
        .i_shift_en  (w_shift_en),
        .o_sout      (sout),
        .o_done      (w_done)
    );

    // Next-state logic: enter SHIFT on a transfer, leave after the last bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with out_ready registered alongside it.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= IDLE;
            r_out_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_ready <= (w_state_nxt == SHIFT);
        end
    end

    // Hold buffer: a capture always wins, so a same-cycle transfer keeps it full.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_hold_reg   <= {ACC_W{1'b0}};
            r_hold_valid <= 1'b0;
        end else if (output_en) begin
            r_hold_reg   <= accum_reg;
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Sticky error flags; only clear can drop them.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (output_en && r_hold_valid && !w_load) begin
                r_overrun <= 1'b1;
            end
            if (frame && w_in_shift) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign out_ready  = r_out_ready;
    assign hold_valid = r_hold_valid;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: doc/alu_out_serializer.md
Name: alu_out_serializer

Overview:
- Downstream stage of the ALU in the MSDAP datapath.
- Captures each 40-bit accumulator result when the ALU strobes output_en, and holds it in a one-deep buffer.
- Shifts the result out serially, MSB first, starting at the next frame boundary.
- One instance per channel; left and right are instantiated separately.

Parameters:
- ACC_W, 40: accumulator/result width in bits; must match the ALU accum_reg width.
- CNT_W, 6: bit counter width; must satisfy 2**CNT_W >= ACC_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset.
- accum_reg  in  ACC_W  ALU result, valid only while output_en=1.
- output_en  in  1  single-cycle strobe from the ALU: capture accum_reg.
- frame  in  1  single-cycle frame-boundary pulse from the controller.
- bit_en  in  1  serial bit-rate enable; advances the shifter by one bit.
- sout  out  1  serial data out, MSB first; equals shift_reg[ACC_W-1].
- out_ready  out  1  high while a word is being presented on sout.
- hold_valid  out  1  the buffer holds a captured word not yet sent.
- overrun  out  1  sticky: a result was overwritten before it was sent.
- frame_err  out  1  sticky: frame arrived while shifting.

Behaviour:
- Reset: clear=1 asynchronously zeroes the following, including mid-shift:
  - hold_reg, shift_reg, bit_cnt;
  - hold_valid, out_ready, sout, overrun, frame_err;
  - state returns to IDLE.
- Capture:
  - On output_en, hold_reg <= accum_reg and hold_valid <= 1 at the next edge.
  - If the buffer is still full and is not emptied by a transfer in the same cycle, set overrun. The newest value wins.
- FSM states: IDLE and SHIFT. out_ready is registered and equals (state==SHIFT).
- IDLE, with frame=1 and hold_valid=1:
  - shift_reg <= hold_reg; bit_cnt <= ACC_W-1; hold_valid <= 0; go to SHIFT.
  - sout shows bit ACC_W-1 one cycle after the frame pulse.
- IDLE, with frame=1 and hold_valid=0: no transfer, sout stays 0, out_ready stays 0.
- IDLE, bit_en: ignored.
- SHIFT, bit_en=1 and bit_cnt != 0: shift_reg <= shift_reg << 1 (LSB filled with 0); bit_cnt decrements.
- SHIFT, bit_en=1 and bit_cnt == 0: go to IDLE; shift_reg <= 0; out_ready drops at the next edge.
- Word length: exactly ACC_W bit_en pulses are consumed per word. Each bit stays stable from one bit_en to the next.
- SHIFT, frame=1: set frame_err. The frame is ignored, the current word continues, and no transfer occurs.
- output_en and frame in the same cycle:
  - Buffer empty: the new word goes to hold_reg and is sent at the following frame.
  - Buffer full and IDLE: the old word transfers to shift_reg and the new word enters hold_reg. hold_valid stays 1 and no overrun is raised.
- frame and bit_en in the same cycle while IDLE: the transfer occurs and bit_en is ignored.
- Last bit_en and frame in the same cycle: the FSM is still in SHIFT, so frame_err is set and no transfer occurs.
- overrun and frame_err clear only on clear.
- Arithmetic: bit_cnt is unsigned CNT_W bits. Data is passed bit-exact with no sign handling or truncation.

Decomposition:
- Shared package msdap_pkg holds:
  - localparam ACC_W=40;
  - typedef ser_state_t enum {IDLE, SHIFT};
  - typedef acc_t logic [ACC_W-1:0].
- Sub-module piso_shift:
  - Contains shift_reg, bit_cnt, load/shift control and the done flag (bit_cnt==0 with bit_en).
  - The top level owns the hold buffer, FSM and error flags.

Test Plan:
- Basic send:
  - Stimulus: clear pulse; output_en with accum_reg=40'h80_0000_0001; frame 5 cycles later; bit_en every 4th cycle.
  - Required: out_ready rises 1 cycle after frame; sout shows 1, then 38 zeros, then 1.
  - Required: out_ready falls after the 40th bit_en; hold_valid falls on the transfer.
- Overrun:
  - Stimulus: output_en with 40'h1; then output_en with 40'h2 before any frame; then frame.
  - Required: overrun=1, and the serial word equals 40'h2.
- Same-cycle load and transfer:
  - Stimulus: hold=40'hAA_AAAA_AAAA while IDLE; in one cycle, output_en with 40'h55_5555_5555 and frame together.
  - Required: the AA word is shifted; hold_valid stays 1 holding 55; overrun=0; the next frame after completion sends 55.
- Frame during shift:
  - Stimulus: a second frame pulse after the 10th bit_en.
  - Required: frame_err=1; the 40-bit word completes unchanged; no new transfer occurs.
- Empty frame:
  - Stimulus: frame with hold_valid=0, followed by 50 bit_en pulses.
  - Required: sout=0 and out_ready=0 throughout.
- Reset mid-shift:
  - Stimulus: assert clear asynchronously, between edges, after the 20th bit_en.
  - Required: all outputs go to 0 immediately; a fresh capture plus frame then sends a full 40-bit word correctly.
